// File: rtl/rs_hs_pipeline_tail.sv
// Credit-returning tail buffer for a pipelined valid/ready body. Upstream may keep
// sending for GRACE_PERIOD cycles after in_ready drops, so the buffer keeps that much slack.
module rs_hs_pipeline_tail #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 24,
  parameter int GRACE_PERIOD    = 9,
  parameter int REAL_DEPTH      = GRACE_PERIOD + DEPTH + 4,
  parameter int REAL_ADDR_WIDTH = $clog2(REAL_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  overflow_err
);

  localparam int CW = $clog2(REAL_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(REAL_DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(REAL_DEPTH - GRACE_PERIOD);
  localparam logic [REAL_ADDR_WIDTH-1:0] LAST = REAL_ADDR_WIDTH'(REAL_DEPTH - 1);

  if (REAL_DEPTH < DEPTH + GRACE_PERIOD) begin : g_bad_depth
    $error("REAL_DEPTH too small to absorb the grace-period beats");
  end

  logic [DATA_WIDTH-1:0]      mem [REAL_DEPTH];
  logic [REAL_ADDR_WIDTH-1:0] wr_ptr;
  logic [REAL_ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic [CW-1:0]              count_next;
  logic                       push;
  logic                       pop;

  function automatic logic [REAL_ADDR_WIDTH-1:0] next_ptr(input logic [REAL_ADDR_WIDTH-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake: a beat moves on a rising edge when valid and ready are both high.
  // On the input side ready is only a credit hint; push depends on free space alone.
  always_comb begin
    pop        = out_valid && out_ready;
    push       = in_valid && ((count < FULL) || pop);
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_ready     <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= next_ptr(wr_ptr);
      if (pop)
        rd_ptr <= next_ptr(rd_ptr);
      count    <= count_next;
      in_ready <= (count_next < THRESH);
      if (in_valid && !push)
        overflow_err <= 1'b1;
    end
  end

  // Storage is never cleared; only the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_rs_hs_pipeline_tail.sv
// Bench for rs_hs_pipeline_tail: a queue-based model checked every cycle, plus
// directed sequences with literal expectations for reset, fill, overflow, wrap and mid-run reset.
module tb_rs_hs_pipeline_tail;

  localparam int RD = 37;
  localparam int TH = 28;

  logic        clk = 0;
  logic        reset = 0;
  logic        in_valid = 0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 0;
  logic        overflow_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  rs_hs_pipeline_tail dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .overflow_err(overflow_err)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // behavioural model: the buffer is a queue, its size is the occupancy
  logic [31:0] exp_q[$];
  bit m_ready = 0;
  bit m_ovf = 0;
  bit m_pop, m_push;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_ready = 0;
      m_ovf = 0;
    end else begin
      m_pop  = (exp_q.size() != 0) && out_ready;
      m_push = in_valid && ((exp_q.size() < RD) || m_pop);
      if (in_valid && !m_push) m_ovf = 1;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(in_data);
      m_ready = (exp_q.size() < TH);
    end
  end

  // scoreboard compare, every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
      chk("in_ready", in_ready, m_ready);
      chk("overflow_err", overflow_err, m_ovf);
      chk("count", dut.count, exp_q.size());
      chk("rd_ptr_range", dut.rd_ptr < RD, 1);
    end
  end

  // driver: set inputs for the next edge, return just after it
  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    in_valid = v;
    in_data = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    out_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  int tx, rx, n;

  initial begin
    #1;
    reset = 1;
    cmp_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_overflow", overflow_err, 0);
    reset = 0;
    #1;
    chk("rel_in_ready_before_edge", in_ready, 0);
    drive(0, 0, 0);
    chk("rel_in_ready_after_edge", in_ready, 1);

    // single beat, held until consumed
    drive(1, 32'hA5, 0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'hA5);
    repeat (3) drive(0, 0, 0);
    chk("single_hold", out_data, 32'hA5);
    drive(0, 0, 1);
    chk("single_gone", out_valid, 0);

    // fill with continuous stream 0..36, no consumer
    for (int i = 0; i < RD; i++) begin
      drive(1, i, 0);
      if (i == TH - 2) chk("ready_before_thresh", in_ready, 1);
      if (i == TH - 1) chk("ready_at_thresh", in_ready, 0);
    end
    chk("fill_count", dut.count, RD);
    chk("fill_ovf", overflow_err, 0);
    chk("fill_head", out_data, 0);

    // 38th beat is dropped
    drive(1, 32'h99, 0);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_count", dut.count, RD);

    // push and pop together while full
    drive(1, 32'h100, 1);
    chk("full_pp_count", dut.count, RD);
    chk("full_pp_head", out_data, 1);

    // drain: 1..36 then 0x100
    for (int i = 1; i <= RD; i++) begin
      chk("drain_order", out_data, (i == RD) ? 32'h100 : i);
      drive(0, 0, 1);
    end
    chk("drain_empty", out_valid, 0);
    chk("ovf_sticky", overflow_err, 1);
    do_reset();
    drive(0, 0, 0);
    chk("ovf_cleared", overflow_err, 0);

    // wrap: 100 incrementing beats, random consumer, sender honours in_ready
    tx = 0; rx = 0; n = 0;
    while ((tx < 100 || out_valid) && n < 3000) begin
      logic v, r;
      v = (tx < 100) && in_ready && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) < 4);
      if (out_valid && r) begin
        chk("wrap_order", out_data, rx);
        rx++;
      end
      drive(v, tx, r);
      if (v) tx++;
      n++;
    end
    if (n >= 3000) chk("wrap_timeout", n, 0);
    chk("wrap_all_out", rx, 100);

    // unconstrained random traffic, including drops beyond the grace window
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 1), $urandom, ($urandom_range(0, 9) < 3));
    do_reset();

    // mid-operation reset
    for (int i = 0; i < 10; i++) drive(1, 32'hB0 + i, 0);
    chk("mid_count", dut.count, 10);
    #2;
    reset = 1;
    #1;
    chk("mid_valid_immediate", out_valid, 0);
    chk("mid_ready_immediate", in_ready, 0);
    #3;
    reset = 0;
    drive(0, 0, 0);
    chk("mid_after_count", dut.count, 0);
    chk("mid_after_valid", out_valid, 0);
    chk("mid_after_ready", in_ready, 1);
    drive(1, 32'h77, 1);
    chk("mid_new_data", out_data, 32'h77);
    drive(0, 0, 1);
    chk("mid_new_gone", out_valid, 0);

    repeat (2) @(posedge clk);
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
